// File: rtl/rr_burst_drain_scheduler_pkg.sv
// Shared definitions for the round-robin burst drain scheduler.
//   state_e         : scheduler state encoding (IDLE=0, BURST=1), also used on
//                     the debug state output.
//   DEF_NUM_FIFOS   : default number of drained FIFOs.
//   DEF_WIDTH       : default data width per FIFO.
//   DEF_MAX_BURST   : default maximum pops per ownership.
//   wrap_add()      : modulo index step that does not assume a power-of-2 count.
package rr_burst_drain_scheduler_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    localparam int DEF_NUM_FIFOS = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_BURST = 4;

    // (base + off) mod n, kept as an explicit modulo so odd FIFO counts wrap correctly.
    function automatic int wrap_add(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/rr_burst_drain_scheduler_if.sv
// Bus bundle between the scheduler, its FIFOs and the downstream consumer.
//   empty        : per-FIFO empty flags            (FIFOs -> scheduler)
//   flat_data_in : packed FIFO heads, FIFO i at [(i+1)*WIDTH-1:i*WIDTH]
//   gnt          : onehot0 pop strobes             (scheduler -> FIFOs)
//   out_data     : registered output word          (scheduler -> consumer)
//   out_tag      : index of the FIFO that supplied out_data
//   out_vld/out_rdy : output handshake
//   busy         : scheduler is in a burst
// Handshake: a word on out_data is transferred on every rising clock edge where
// out_vld and out_rdy are both 1; out_vld never drops without such a transfer,
// and out_data/out_tag are stable while out_vld=1 and out_rdy=0.
// master is the scheduler side, slave is the FIFO/consumer side.
interface rr_burst_drain_scheduler_if
    import rr_burst_drain_scheduler_pkg::*;
#(
    parameter int NUM_FIFOS = DEF_NUM_FIFOS,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS)
);
    logic [NUM_FIFOS-1:0]       empty;
    logic [NUM_FIFOS*WIDTH-1:0] flat_data_in;
    logic [NUM_FIFOS-1:0]       gnt;
    logic [WIDTH-1:0]           out_data;
    logic [TAGWIDTH-1:0]        out_tag;
    logic                       out_vld;
    logic                       out_rdy;
    logic                       busy;

    modport master (
        input  empty, flat_data_in, out_rdy,
        output gnt, out_data, out_tag, out_vld, busy
    );

    modport slave (
        output empty, flat_data_in, out_rdy,
        input  gnt, out_data, out_tag, out_vld, busy
    );
endinterface

// File: rtl/rr_burst_drain_scheduler_rr_pick.sv
// Combinational rotate-priority search.
//   req     : request vector (one bit per FIFO)
//   last    : index of the previous owner; the search starts at last+1
//   next    : first requesting index in last+1, last+2, ... mod N (last itself
//             is checked last); equals last when nothing requests
//   any_req : at least one request bit is set
module rr_pick
    import rr_burst_drain_scheduler_pkg::*;
#(
    parameter int N  = DEF_NUM_FIFOS,
    parameter int TW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [TW-1:0] last,
    output logic [TW-1:0] next,
    output logic          any_req
);
    int idx;

    always_comb begin
        next    = last;
        idx     = 0;
        any_req = |req;
        // Walk farthest-first so the nearest requester after last overwrites.
        for (int k = N; k >= 1; k--) begin
            idx = wrap_add(int'(last), k, N);
            if (req[idx]) begin
                next = TW'(idx);
            end
        end
    end
endmodule

// File: rtl/rr_burst_drain_scheduler.sv
// Round-robin scheduler draining NUM_FIFOS FIFOs into one registered output.
// Ownership is granted to one FIFO for up to MAX_BURST pops, then a new owner is
// searched starting just after the old one. Selecting an owner costs one IDLE cycle.
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   bus        : master side of rr_burst_drain_scheduler_if (FIFO flags/heads,
//                pop strobes, output register and handshake, busy)
//   dbg_state  : current FSM state
//   dbg_owner  : current (or last) owner index
//   dbg_cnt    : pops done in the current burst
module rr_burst_drain_scheduler
    import rr_burst_drain_scheduler_pkg::*;
#(
    parameter int NUM_FIFOS = DEF_NUM_FIFOS,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS),
    parameter int CNTW      = $clog2(MAX_BURST + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    rr_burst_drain_scheduler_if.master bus,
    output state_e              dbg_state,
    output logic [TAGWIDTH-1:0] dbg_owner,
    output logic [CNTW-1:0]     dbg_cnt
);
    state_e               state;
    logic [TAGWIDTH-1:0]  owner;
    logic [CNTW-1:0]      cnt;
    logic [WIDTH-1:0]     out_data_q;
    logic [TAGWIDTH-1:0]  out_tag_q;
    logic                 out_vld_q;

    logic [TAGWIDTH-1:0]  pick_idx;
    logic                 pick_any;
    logic                 can_load;
    logic                 owner_empty;
    logic                 pop;
    logic                 last_beat;
    logic [WIDTH-1:0]     head;
    logic [NUM_FIFOS-1:0] gnt_w;

    rr_pick #(
        .N  (NUM_FIFOS),
        .TW (TAGWIDTH)
    ) u_pick (
        .req     (~bus.empty),
        .last    (owner),
        .next    (pick_idx),
        .any_req (pick_any)
    );

    // The output register can take a new word if it is free or being consumed now.
    assign can_load    = !out_vld_q || bus.out_rdy;
    assign owner_empty = bus.empty[owner];
    assign pop         = (state == BURST) && can_load && !owner_empty;
    assign last_beat   = (cnt == CNTW'(MAX_BURST - 1));
    assign head        = bus.flat_data_in[owner*WIDTH +: WIDTH];

    always_comb begin
        gnt_w = '0;
        if (pop) begin
            gnt_w[owner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= TAGWIDTH'(NUM_FIFOS - 1);
            cnt        <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_tag_q  <= '0;
        end else begin
            // A pop always refills the output; otherwise a consumed word empties it.
            if (pop) begin
                out_data_q <= head;
                out_tag_q  <= owner;
                out_vld_q  <= 1'b1;
            end else if (out_vld_q && bus.out_rdy) begin
                out_vld_q  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner <= pick_idx;
                        cnt   <= '0;
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (pop) begin
                        cnt <= cnt + CNTW'(1);
                    end
                    // owner is left as-is so the next search rotates past it.
                    if ((pop && last_beat) || owner_empty) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt      = gnt_w;
    assign bus.out_data = out_data_q;
    assign bus.out_tag  = out_tag_q;
    assign bus.out_vld  = out_vld_q;
    assign bus.busy     = (state != IDLE);

    assign dbg_state = state;
    assign dbg_owner = owner;
    assign dbg_cnt   = cnt;

    // Structural invariants of the grant logic.
    always @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0(gnt_w));
            assert ((gnt_w & bus.empty) == '0);
            assert ((gnt_w == '0) || (state == BURST));
            assert ((state != BURST) || (cnt <= CNTW'(MAX_BURST - 1)));
        end
    end
endmodule
